// File: rtl/misc_v_pkg.sv
// Shared definitions for the MISC-V pipeline control blocks.
//   FWD_RF / FWD_MEM / FWD_WB : EX operand source selects
//   load_st_t                 : load-use stall FSM states
//   flush_st_t                : redirect flush sequencer states
package misc_v_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        L_IDLE = 1'b0,
        L_WAIT = 1'b1
    } load_st_t;

    typedef enum logic {
        F_IDLE  = 1'b0,
        F_FLUSH = 1'b1
    } flush_st_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one EX operand.
//   ex_rs          : EX-stage source register of this operand
//   rd_mem, we_mem : MEM-stage destination and write enable
//   rd_wb, we_wb   : WB-stage destination and write enable
//   fwd            : FWD_MEM / FWD_WB / FWD_RF (MEM wins over WB)
module hazard_fwd_sel
    import misc_v_pkg::*;
#(
    parameter int REG_AW   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] rd_mem,
    input  logic              we_mem,
    input  logic [REG_AW-1:0] rd_wb,
    input  logic              we_wb,
    output logic [1:0]        fwd
);

    // A write to the hardwired zero register never produces a value to forward.
    function automatic logic reg_match(logic [REG_AW-1:0] x, logic [REG_AW-1:0] y);
        return (x == y) && !((ZERO_REG != 0) && (y == {REG_AW{1'b0}}));
    endfunction

    // Priority mux: the younger MEM result shadows the older WB result.
    always_comb begin
        fwd = FWD_RF;
        if (we_mem && reg_match(ex_rs, rd_mem)) begin
            fwd = FWD_MEM;
        end else if (we_wb && reg_match(ex_rs, rd_wb)) begin
            fwd = FWD_WB;
        end else begin
            fwd = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit for the in-order MISC-V pipeline.
//   Inputs : ID-stage sources (id_valid, rs1/rs2, rs*_used), EX sources
//            (ex_rs1/ex_rs2), EX/MEM/WB destinations and write enables,
//            mem_read (EX is a load), mem_busy, redirect (taken branch pulse).
//   Outputs: stall (hold PC + IF/ID, bubble EX), flush (squash IF/ID, ID/EX),
//            fwd_a / fwd_b (EX operand selects), stall_count (saturating).
// Load-use stalls stretch to LOAD_LAT cycles through a small wait FSM; each
// redirect keeps flush high for FLUSH_CYCLES cycles. Flush overrides stall.
module hazard_ctrl
    import misc_v_pkg::*;
#(
    parameter int REG_AW       = 2,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_CYCLES = 2,
    parameter int ZERO_REG     = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] rdEX,
    input  logic              write_enable_ex,
    input  logic              mem_read,
    input  logic [REG_AW-1:0] rdMEM,
    input  logic              write_enable_mem,
    input  logic [REG_AW-1:0] rdWB,
    input  logic              write_enable_wb,
    input  logic              mem_busy,
    input  logic              redirect,
    output logic              stall,
    output logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_count
);

    // The first stall cycle comes from the combinational detect, so the wait
    // FSM only covers the remaining LOAD_LAT-1 cycles (likewise for flush).
    localparam logic [2:0] LCNT_INIT   = 3'(LOAD_LAT - 1);
    localparam logic [2:0] FCNT_INIT   = 3'(FLUSH_CYCLES - 1);
    localparam bit         LOAD_MULTI  = (LOAD_LAT > 1);
    localparam bit         FLUSH_MULTI = (FLUSH_CYCLES > 1);

    load_st_t         load_st_r, load_st_nxt_s;
    flush_st_t        flush_st_r, flush_st_nxt_s;
    logic [2:0]       lcnt_r, lcnt_nxt_s;
    logic [2:0]       fcnt_r, fcnt_nxt_s;
    logic [CNT_W-1:0] stall_count_r;
    logic             lu_s, flush_s, stall_s;
    logic [1:0]       fwd_a_s, fwd_b_s;

    function automatic logic reg_match(logic [REG_AW-1:0] x, logic [REG_AW-1:0] y);
        return (x == y) && !((ZERO_REG != 0) && (y == {REG_AW{1'b0}}));
    endfunction

    assign lu_s = id_valid && mem_read && write_enable_ex &&
                  ((rs1_used && reg_match(rs1, rdEX)) || (rs2_used && reg_match(rs2, rdEX)));

    // Outputs are forced quiet while reset is held, even with live inputs.
    assign flush_s = rst_n && (redirect || (flush_st_r == F_FLUSH));
    assign stall_s = rst_n && !flush_s && (lu_s || (load_st_r == L_WAIT) || mem_busy);

    assign flush       = flush_s;
    assign stall       = stall_s;
    assign fwd_a       = rst_n ? fwd_a_s : FWD_RF;
    assign fwd_b       = rst_n ? fwd_b_s : FWD_RF;
    assign stall_count = stall_count_r;

    hazard_fwd_sel #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_a (
        .ex_rs  (ex_rs1),
        .rd_mem (rdMEM),
        .we_mem (write_enable_mem),
        .rd_wb  (rdWB),
        .we_wb  (write_enable_wb),
        .fwd    (fwd_a_s)
    );

    hazard_fwd_sel #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_b (
        .ex_rs  (ex_rs2),
        .rd_mem (rdMEM),
        .we_mem (write_enable_mem),
        .rd_wb  (rdWB),
        .we_wb  (write_enable_wb),
        .fwd    (fwd_b_s)
    );

    // Load-wait next state: entry only on an unfrozen, unflushed load-use;
    // aging pauses while memory is busy; a flush squashes the waiter.
    always_comb begin
        load_st_nxt_s = load_st_r;
        lcnt_nxt_s    = lcnt_r;
        case (load_st_r)
            L_IDLE: begin
                if (LOAD_MULTI && lu_s && !flush_s && !mem_busy) begin
                    load_st_nxt_s = L_WAIT;
                    lcnt_nxt_s    = LCNT_INIT;
                end else begin
                    load_st_nxt_s = L_IDLE;
                    lcnt_nxt_s    = 3'd0;
                end
            end
            L_WAIT: begin
                if (flush_s) begin
                    load_st_nxt_s = L_IDLE;
                    lcnt_nxt_s    = 3'd0;
                end else if (mem_busy) begin
                    load_st_nxt_s = L_WAIT;
                    lcnt_nxt_s    = lcnt_r;
                end else if (lcnt_r <= 3'd1) begin
                    load_st_nxt_s = L_IDLE;
                    lcnt_nxt_s    = 3'd0;
                end else begin
                    load_st_nxt_s = L_WAIT;
                    lcnt_nxt_s    = lcnt_r - 3'd1;
                end
            end
            default: begin
                load_st_nxt_s = L_IDLE;
                lcnt_nxt_s    = 3'd0;
            end
        endcase
    end

    // Flush sequencer next state: any redirect (re)starts the countdown.
    always_comb begin
        flush_st_nxt_s = flush_st_r;
        fcnt_nxt_s     = fcnt_r;
        case (flush_st_r)
            F_IDLE: begin
                if (FLUSH_MULTI && redirect) begin
                    flush_st_nxt_s = F_FLUSH;
                    fcnt_nxt_s     = FCNT_INIT;
                end else begin
                    flush_st_nxt_s = F_IDLE;
                    fcnt_nxt_s     = 3'd0;
                end
            end
            F_FLUSH: begin
                if (redirect) begin
                    flush_st_nxt_s = F_FLUSH;
                    fcnt_nxt_s     = FCNT_INIT;
                end else if (fcnt_r <= 3'd1) begin
                    flush_st_nxt_s = F_IDLE;
                    fcnt_nxt_s     = 3'd0;
                end else begin
                    flush_st_nxt_s = F_FLUSH;
                    fcnt_nxt_s     = fcnt_r - 3'd1;
                end
            end
            default: begin
                flush_st_nxt_s = F_IDLE;
                fcnt_nxt_s     = 3'd0;
            end
        endcase
    end

    // State registers for both FSMs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_st_r  <= L_IDLE;
            lcnt_r     <= 3'd0;
            flush_st_r <= F_IDLE;
            fcnt_r     <= 3'd0;
        end else begin
            load_st_r  <= load_st_nxt_s;
            lcnt_r     <= lcnt_nxt_s;
            flush_st_r <= flush_st_nxt_s;
            fcnt_r     <= fcnt_nxt_s;
        end
    end

    // Stall-cycle performance counter, sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_count_r != {CNT_W{1'b1}})) begin
            stall_count_r <= stall_count_r + CNT_W'(1);
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a default instance and a second one
// with LOAD_LAT=3, FLUSH_CYCLES=3, CNT_W=4 share every input. Outputs are
// compared against a counter-based model of the pipeline rules, plus a
// table of fixed single-cycle vectors and hand-written corner sequences.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       id_valid, rs1_used, rs2_used, we_ex, mem_read, we_mem, we_wb;
    logic       mem_busy, redirect;
    logic [1:0] rs1, rs2, ex_rs1, ex_rs2, rd_ex, rd_mem, rd_wb;

    logic        stall0, flush0, stall1, flush1;
    logic [1:0]  fa0, fb0, fa1, fb1;
    logic [15:0] cnt0;
    logic [3:0]  cnt1;

    hazard_ctrl u_dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .rs1(rs1), .rs2(rs2),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .rdEX(rd_ex), .write_enable_ex(we_ex), .mem_read(mem_read), .rdMEM(rd_mem),
        .write_enable_mem(we_mem), .rdWB(rd_wb), .write_enable_wb(we_wb),
        .mem_busy(mem_busy), .redirect(redirect), .stall(stall0), .flush(flush0),
        .fwd_a(fa0), .fwd_b(fb0), .stall_count(cnt0)
    );

    hazard_ctrl #(.LOAD_LAT(3), .FLUSH_CYCLES(3), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .rs1(rs1), .rs2(rs2),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .rdEX(rd_ex), .write_enable_ex(we_ex), .mem_read(mem_read), .rdMEM(rd_mem),
        .write_enable_mem(we_mem), .rdWB(rd_wb), .write_enable_wb(we_wb),
        .mem_busy(mem_busy), .redirect(redirect), .stall(stall1), .flush(flush1),
        .fwd_a(fa1), .fwd_b(fb1), .stall_count(cnt1)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: per instance, cycles still to wait behind a load,
    // flush cycles still owed after the current one, and the stall count.
    int   m_ll[2]   = '{1, 3};
    int   m_fc[2]   = '{2, 3};
    int   m_max[2]  = '{65535, 15};
    int   load_left[2];
    int   flush_left[2];
    int   cnt_m[2];
    logic e_stall[2], e_flush[2];
    logic [1:0] e_fa, e_fb;
    logic lu_m;

    function automatic bit mt(logic [1:0] x, logic [1:0] y);
        return (x == y) && (y != 2'd0);
    endfunction

    function automatic logic [1:0] fsel(logic [1:0] r);
        if (we_mem && mt(r, rd_mem)) return 2'b01;
        if (we_wb && mt(r, rd_wb)) return 2'b10;
        return 2'b00;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            load_left[i] = 0; flush_left[i] = 0; cnt_m[i] = 0;
        end
    endtask

    task automatic model_check();
        lu_m = id_valid && mem_read && we_ex &&
               ((rs1_used && mt(rs1, rd_ex)) || (rs2_used && mt(rs2, rd_ex)));
        for (int i = 0; i < 2; i++) begin
            e_flush[i] = redirect || (flush_left[i] > 0);
            e_stall[i] = !e_flush[i] && (lu_m || (load_left[i] > 0) || mem_busy);
        end
        e_fa = fsel(ex_rs1);
        e_fb = fsel(ex_rs2);
        chk("m_stall0", stall0, e_stall[0]); chk("m_flush0", flush0, e_flush[0]);
        chk("m_fwd_a0", fa0, e_fa);          chk("m_fwd_b0", fb0, e_fb);
        chk("m_count0", cnt0, cnt_m[0]);
        chk("m_stall1", stall1, e_stall[1]); chk("m_flush1", flush1, e_flush[1]);
        chk("m_fwd_a1", fa1, e_fa);          chk("m_fwd_b1", fb1, e_fb);
        chk("m_count1", cnt1, cnt_m[1]);
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (e_stall[i] && cnt_m[i] < m_max[i]) cnt_m[i]++;
            if (load_left[i] > 0) begin
                if (e_flush[i]) load_left[i] = 0;
                else if (!mem_busy) load_left[i]--;
            end else if (lu_m && !e_flush[i] && !mem_busy) begin
                load_left[i] = m_ll[i] - 1;
            end
            if (redirect) flush_left[i] = m_fc[i] - 1;
            else if (flush_left[i] > 0) flush_left[i]--;
        end
    endtask

    task automatic half();
        @(negedge clk);
        model_check();
    endtask

    task automatic tail();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cyc();
        half();
        tail();
    endtask

    task automatic clr();
        id_valid = 1'b0; rs1 = 2'd0; rs2 = 2'd0; rs1_used = 1'b0; rs2_used = 1'b0;
        ex_rs1 = 2'd0; ex_rs2 = 2'd0; rd_ex = 2'd0; we_ex = 1'b0; mem_read = 1'b0;
        rd_mem = 2'd0; we_mem = 1'b0; rd_wb = 2'd0; we_wb = 1'b0;
        mem_busy = 1'b0; redirect = 1'b0;
    endtask

    task automatic set_lu();
        id_valid = 1'b1; rs1 = 2'd1; rs1_used = 1'b1; rd_ex = 2'd1;
        mem_read = 1'b1; we_ex = 1'b1;
    endtask

    typedef struct {
        logic       id_valid;
        logic [1:0] rs1;    logic rs1_used;
        logic [1:0] rs2;    logic rs2_used;
        logic [1:0] rd_ex;  logic we_ex; logic mem_read;
        logic [1:0] ex_rs1; logic [1:0] ex_rs2;
        logic [1:0] rd_mem; logic we_mem;
        logic [1:0] rd_wb;  logic we_wb;
        logic       mem_busy;
        logic       x_stall; logic [1:0] x_fa; logic [1:0] x_fb;
    } vec_t;

    vec_t tbl[11];

    initial begin
        // id rs1 u rs2 u  rdex we ld  exr1 exr2  rdm wm  rdw ww  busy  stall fa fb
        tbl[0]  = '{0, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0,  0, 0,  0,  0, 2'b00, 2'b00};
        tbl[1]  = '{1, 0, 1, 0, 0,  0, 1, 1,  0, 0,  0, 1,  0, 0,  0,  0, 2'b00, 2'b00};
        tbl[2]  = '{0, 0, 0, 0, 0,  0, 0, 0,  1, 2,  2, 1,  2, 1,  0,  0, 2'b00, 2'b01};
        tbl[3]  = '{0, 0, 0, 0, 0,  0, 0, 0,  1, 2,  2, 0,  2, 1,  0,  0, 2'b00, 2'b10};
        tbl[4]  = '{1, 0, 0, 3, 1,  3, 1, 1,  0, 0,  0, 0,  0, 0,  0,  1, 2'b00, 2'b00};
        tbl[5]  = '{1, 0, 0, 3, 0,  3, 1, 1,  0, 0,  0, 0,  0, 0,  0,  0, 2'b00, 2'b00};
        tbl[6]  = '{1, 0, 0, 3, 1,  3, 1, 0,  0, 0,  0, 0,  0, 0,  0,  0, 2'b00, 2'b00};
        tbl[7]  = '{0, 0, 0, 3, 1,  3, 1, 1,  0, 0,  0, 0,  0, 0,  0,  0, 2'b00, 2'b00};
        tbl[8]  = '{0, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0,  0, 0,  1,  1, 2'b00, 2'b00};
        tbl[9]  = '{0, 0, 0, 0, 0,  0, 0, 0,  3, 1,  3, 0,  3, 1,  0,  0, 2'b10, 2'b00};
        tbl[10] = '{0, 0, 0, 0, 0,  0, 0, 0,  2, 2,  2, 1,  1, 1,  0,  0, 2'b01, 2'b01};

        // Reset state.
        clr();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", stall0, 0); chk("rst_flush", flush0, 0);
        chk("rst_fwd_a", fa0, 0);    chk("rst_count0", cnt0, 0);
        chk("rst_count1", cnt1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load-use: one cycle with LOAD_LAT=1, three with LOAD_LAT=3.
        set_lu();
        half(); chk("lu_stall", stall0, 1); chk("lu_flush", flush0, 0); tail();
        clr();
        half(); chk("lu_end", stall0, 0); chk("lu_count", cnt0, 1);
                chk("ll3_c2", stall1, 1); tail();
        half(); chk("ll3_c3", stall1, 1); tail();
        half(); chk("ll3_end", stall1, 0); chk("ll3_count", cnt1, 3); tail();

        // LOAD_LAT=3 with memory busy on stall cycles 2 and 3.
        set_lu(); cyc();
        clr(); mem_busy = 1'b1; cyc(); cyc();
        mem_busy = 1'b0;
        half(); chk("busy_c4", stall1, 1); tail();
        half(); chk("busy_c5", stall1, 1); tail();
        half(); chk("busy_end", stall1, 0); chk("busy_count", cnt1, 8); tail();

        // Redirect while a load-use is present: flush wins.
        set_lu(); redirect = 1'b1;
        half(); chk("rdr_c1_flush", flush0, 1); chk("rdr_c1_stall", stall0, 0); tail();
        redirect = 1'b0;
        half(); chk("rdr_c2_flush", flush0, 1); chk("rdr_c2_stall", stall0, 0); tail();
        clr();
        half(); chk("rdr_c3_flush", flush0, 0); chk("rdr_c3_stall", stall0, 0); tail();
        cyc();

        // Second redirect on cycle 2 restarts the flush window.
        redirect = 1'b1; cyc(); cyc();
        redirect = 1'b0;
        half(); chk("rdr_ext_c3", flush0, 1); tail();
        half(); chk("rdr_ext_c4", flush0, 0); tail();
        cyc(); cyc();

        // Flush during the load wait squashes it (busy keeps it from aging).
        set_lu(); cyc();
        clr(); redirect = 1'b1; mem_busy = 1'b1; cyc();
        redirect = 1'b0; cyc(); cyc();
        mem_busy = 1'b0;
        half(); chk("lw_squash_stall", stall1, 0); chk("lw_squash_flush", flush1, 0); tail();

        // Fixed single-cycle vectors against the default instance.
        for (int i = 0; i < 11; i++) begin
            id_valid = tbl[i].id_valid; rs1 = tbl[i].rs1; rs1_used = tbl[i].rs1_used;
            rs2 = tbl[i].rs2; rs2_used = tbl[i].rs2_used; rd_ex = tbl[i].rd_ex;
            we_ex = tbl[i].we_ex; mem_read = tbl[i].mem_read; ex_rs1 = tbl[i].ex_rs1;
            ex_rs2 = tbl[i].ex_rs2; rd_mem = tbl[i].rd_mem; we_mem = tbl[i].we_mem;
            rd_wb = tbl[i].rd_wb; we_wb = tbl[i].we_wb; mem_busy = tbl[i].mem_busy;
            redirect = 1'b0;
            half();
            chk($sformatf("vec%0d_stall", i), stall0, tbl[i].x_stall);
            chk($sformatf("vec%0d_fwd_a", i), fa0, tbl[i].x_fa);
            chk($sformatf("vec%0d_fwd_b", i), fb0, tbl[i].x_fb);
            tail();
        end
        clr(); cyc(); cyc(); cyc();

        // Saturation of the 4-bit counter.
        mem_busy = 1'b1;
        repeat (20) cyc();
        mem_busy = 1'b0;
        half(); chk("sat_count", cnt1, 15); tail();

        // Random traffic against the model.
        repeat (400) begin
            id_valid = 1'($urandom); rs1 = 2'($urandom); rs2 = 2'($urandom);
            rs1_used = 1'($urandom); rs2_used = 1'($urandom);
            ex_rs1 = 2'($urandom); ex_rs2 = 2'($urandom); rd_ex = 2'($urandom);
            we_ex = 1'($urandom); mem_read = 1'($urandom);
            rd_mem = 2'($urandom); we_mem = 1'($urandom);
            rd_wb = 2'($urandom); we_wb = 1'($urandom);
            mem_busy = ($urandom_range(0, 4) == 0);
            redirect = ($urandom_range(0, 9) == 0);
            cyc();
        end

        // Asynchronous reset in the middle of a flush, with live inputs.
        clr(); redirect = 1'b1; cyc();
        redirect = 1'b1; mem_busy = 1'b1; ex_rs1 = 2'd1; rd_mem = 2'd1; we_mem = 1'b1;
        ex_rs2 = 2'd2; rd_wb = 2'd2; we_wb = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_flush", flush0, 0); chk("arst_stall", stall0, 0);
        chk("arst_fwd_a", fa0, 0);    chk("arst_fwd_b", fb0, 0);
        chk("arst_count0", cnt0, 0);  chk("arst_count1", cnt1, 0);
        chk("arst_flush1", flush1, 0);
        model_reset();
        clr();
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        half(); chk("post_rst_flush", flush0, 0); chk("post_rst_stall", stall0, 0); tail();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
